// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU request arbiter: opcodes, FSM states, command layout.
// Pure declarations; no latency or flow-control behaviour of its own.
// Opcodes 2 and 3 are unused by the ALU and may be filtered at the arbiter.
package alu_arb_pkg;

  localparam int TAG_DEPTH = 8;
  localparam int TAG_CNT_W = $clog2(TAG_DEPTH) + 1;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    EQ  = 3'd4,
    GT  = 3'd5,
    LT  = 3'd6,
    EZ  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PRESS,
    ST_SETTLE
  } arb_state_e;

  // op stays a raw 3-bit field so undefined opcodes can be carried and detected.
  typedef struct packed {
    logic [2:0] op;
    logic [5:0] a;
    logic [5:0] b;
  } alu_cmd_t;

  function automatic logic is_invalid_op(input logic [2:0] op);
    return !(op inside {ADD, SUB, EQ, GT, LT, EZ});
  endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Bundle of requester, ALU drive and result-return signals around the arbiter.
// No storage; master is the requester/ALU side, slave is the arbiter.
// Grants are pulses; requesters hold req until they see their gnt bit.
interface alu_req_arbiter_if;
  import alu_arb_pkg::*;

  logic [1:0] req;
  alu_cmd_t   cmd0;
  alu_cmd_t   cmd1;
  logic [1:0] gnt;
  logic       rd_req;
  logic       full;
  logic       empty;
  logic [5:0] RESULT;
  logic       wren;
  logic       button;
  alu_cmd_t   dataIn;
  logic       rd_done;
  logic       rd_src;
  logic [5:0] result_out;
  logic       busy;

  modport master (
    output req, cmd0, cmd1, rd_req, full, empty, RESULT,
    input  gnt, wren, button, dataIn, rd_done, rd_src, result_out, busy
  );

  modport slave (
    input  req, cmd0, cmd1, rd_req, full, empty, RESULT,
    output gnt, wren, button, dataIn, rd_done, rd_src, result_out, busy
  );

endinterface

// File: rtl/alu_tag_fifo.sv
// 8x1 FIFO remembering which requester issued each write still held in the ALU.
// Push/pop take effect on the clock edge; head is readable combinationally.
// No backpressure: the caller never pushes when full or pops when empty.
module alu_tag_fifo
  import alu_arb_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 wr_dat,
  input  logic                 pop,
  output logic                 rd_dat,
  output logic [TAG_CNT_W-1:0] count
);

  localparam int PW = $clog2(TAG_DEPTH);

  logic [TAG_DEPTH-1:0] mem;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;

  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Arbitrates two write requesters and a read drain onto a button-strobed ALU.
// Latency: gnt/start to IDLE (or rd_done) is GAP_CYCLES+PRESS_CYCLES+2 cycles.
// Backpressure via full/empty/tag count; ALU_ARB_INVALID_FILTER_EN drops opcodes 2/3.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input logic               clock,
  input logic               reset,
  alu_req_arbiter_if.slave  bus
);

  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] PRESS_LAST = 16'(PRESS_CYCLES - 1);

  arb_state_e           state;
  logic [15:0]          cnt;
  logic                 rr_ptr;
  logic                 last_rd;
  logic                 cur_id;
  logic [1:0]           gnt_q;
  logic                 wren_q;
  logic                 button_q;
  alu_cmd_t             data_q;
  logic                 rd_done_q;
  logic                 rd_src_q;
  logic [5:0]           result_q;

  logic [TAG_CNT_W-1:0] tag_cnt;
  logic                 tag_head;
  logic                 tag_push;
  logic                 tag_pop;
  logic                 wr_elig;
  logic                 rd_elig;
  logic                 pick_rd;
  logic                 win_id;
  logic                 skip_wr;
  alu_cmd_t             win_cmd;

  always_comb begin
    wr_elig  = (|bus.req) && !bus.full && (tag_cnt < TAG_CNT_W'(TAG_DEPTH));
    rd_elig  = bus.rd_req && !bus.empty && (tag_cnt != '0);
    // Alternate op types under contention; last_rd resets to 0 so a read goes first.
    pick_rd  = rd_elig && (!wr_elig || !last_rd);
    win_id   = bus.req[rr_ptr] ? rr_ptr : ~rr_ptr;
    win_cmd  = win_id ? bus.cmd1 : bus.cmd0;
`ifdef ALU_ARB_INVALID_FILTER_EN
    skip_wr  = is_invalid_op(win_cmd.op);
`else
    skip_wr  = 1'b0;
`endif
    tag_push = (state == ST_PRESS) && (cnt == PRESS_LAST) && wren_q;
    tag_pop  = (state == ST_SETTLE) && (cnt == 16'd1) && !wren_q;
  end

  alu_tag_fifo u_tag_fifo (
    .clock  (clock),
    .reset  (reset),
    .push   (tag_push),
    .wr_dat (cur_id),
    .pop    (tag_pop),
    .rd_dat (tag_head),
    .count  (tag_cnt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rr_ptr    <= 1'b0;
      last_rd   <= 1'b0;
      cur_id    <= 1'b0;
      gnt_q     <= '0;
      wren_q    <= 1'b0;
      button_q  <= 1'b1;
      data_q    <= '0;
      rd_done_q <= 1'b0;
      rd_src_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      gnt_q     <= '0;
      rd_done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pick_rd) begin
            wren_q  <= 1'b0;
            last_rd <= 1'b1;
            cnt     <= '0;
            state   <= ST_SETUP;
          end else if (wr_elig) begin
            gnt_q  <= win_id ? 2'b10 : 2'b01;
            rr_ptr <= ~win_id;
            if (!skip_wr) begin
              data_q  <= win_cmd;
              wren_q  <= 1'b1;
              cur_id  <= win_id;
              last_rd <= 1'b0;
              cnt     <= '0;
              state   <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (cnt == GAP_LAST) begin
            cnt      <= '0;
            button_q <= 1'b0;
            state    <= ST_PRESS;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_PRESS: begin
          if (cnt == PRESS_LAST) begin
            cnt      <= '0;
            button_q <= 1'b1;
            state    <= ST_SETTLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_SETTLE: begin
          if (cnt == 16'd1) begin
            cnt   <= '0;
            state <= ST_IDLE;
            if (!wren_q) begin
              result_q  <= bus.RESULT;
              rd_src_q  <= tag_head;
              rd_done_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.wren       = wren_q;
  assign bus.button     = button_q;
  assign bus.dataIn     = data_q;
  assign bus.rd_done    = rd_done_q;
  assign bus.rd_src     = rd_src_q;
  assign bus.result_out = result_q;
  assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model (tag queue, RR priority, last op type).
module tb_alu_req_arbiter;
  import alu_arb_pkg::*;

  localparam int GAP   = 4;
  localparam int PRESS = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  alu_req_arbiter_if bus();

  alu_req_arbiter #(.PRESS_CYCLES(PRESS), .GAP_CYCLES(GAP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model state
  int tags[$];
  bit last_rd;
  bit prio;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req    = 2'b00;
    bus.cmd0   = '0;
    bus.cmd1   = '0;
    bus.rd_req = 1'b0;
    bus.full   = 1'b0;
    bus.empty  = 1'b0;
    bus.RESULT = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset = 1'b1;
    tags.delete();
    last_rd = 1'b0;
    prio    = 1'b0;
    tick();
  endtask

  function automatic logic [14:0] rand_cmd();
    logic [2:0] ops [6];
    ops = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    return {ops[$urandom_range(0, 5)], 6'($urandom), 6'($urandom)};
  endfunction

  // One decision in IDLE followed by the whole resulting operation.
  task automatic do_txn(input logic [1:0] rq, input logic [14:0] c0, input logic [14:0] c1,
                        input logic rr, input logic fl, input logic em, input logic [5:0] res,
                        input string tag, output logic [1:0] g_seen);
    bit wr_ok, rd_ok, do_rd, do_wr, filt, go;
    int win, n, low, first_low, dones, gnts;
    logic [14:0] wcmd;
    logic got_src;
    logic [5:0] got_res;
    wr_ok = (rq != 2'b00) && !fl && (tags.size() < 8);
    rd_ok = rr && !em && (tags.size() > 0);
    do_rd = rd_ok && (!wr_ok || !last_rd);
    do_wr = wr_ok && !do_rd;
    win   = rq[prio] ? int'(prio) : 1 - int'(prio);
    wcmd  = (win == 1) ? c1 : c0;
    filt  = 1'b0;
`ifdef ALU_ARB_INVALID_FILTER_EN
    filt  = do_wr && (wcmd[14:12] == 3'd2 || wcmd[14:12] == 3'd3);
`endif
    go = do_rd || (do_wr && !filt);

    bus.req = rq; bus.cmd0 = c0; bus.cmd1 = c1; bus.rd_req = rr;
    bus.full = fl; bus.empty = em; bus.RESULT = res;
    tick();
    g_seen = bus.gnt;
    chk({tag, ".gnt"}, 32'(bus.gnt), do_wr ? (32'd1 << win) : 32'd0);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(go));
    if (do_wr && !filt) begin
      chk({tag, ".dataIn"}, 32'(bus.dataIn), 32'(wcmd));
      chk({tag, ".wren"}, 32'(bus.wren), 32'd1);
    end
    if (do_rd) chk({tag, ".wren_rd"}, 32'(bus.wren), 32'd0);
    bus.req = 2'b00; bus.rd_req = 1'b0;
    // Status flips mid-operation must not abort anything.
    bus.full = ~fl; bus.empty = ~em;
    if (do_wr) prio = (win == 0);

    if (go) begin
      n = 0; low = 0; first_low = -1; dones = 0; gnts = 0;
      got_src = 1'b0; got_res = '0;
      while (n < 100) begin
        tick();
        n++;
        if (bus.button === 1'b0) begin
          low++;
          if (first_low < 0) first_low = n;
        end
        if (bus.rd_done === 1'b1) begin
          dones++;
          got_src = bus.rd_src;
          got_res = bus.result_out;
        end
        if (bus.gnt !== 2'b00) gnts++;
        if (bus.busy === 1'b0) break;
      end
      chk({tag, ".latency"}, 32'(n), 32'(GAP + PRESS + 2));
      chk({tag, ".press_len"}, 32'(low), 32'(PRESS));
      chk({tag, ".gap_len"}, 32'(first_low), 32'(GAP));
      chk({tag, ".rd_done_cnt"}, 32'(dones), 32'(do_rd));
      chk({tag, ".extra_gnt"}, 32'(gnts), 32'd0);
      if (do_rd) begin
        chk({tag, ".rd_src"}, 32'(got_src), 32'(tags[0]));
        chk({tag, ".result_out"}, 32'(got_res), 32'(res));
        void'(tags.pop_front());
        last_rd = 1'b1;
      end else begin
        tags.push_back(win);
        last_rd = 1'b0;
      end
    end
    chk({tag, ".tag_cnt"}, 32'(dut.u_tag_fifo.count), 32'(tags.size()));
    bus.full = 1'b0; bus.empty = 1'b0;
  endtask

  initial begin
    logic [1:0] g;
    logic [1:0] exp_seq [4];
    int low, bsy;

    // Reset values while reset is held low
    reset = 1'b0;
    idle_inputs();
    tags.delete(); last_rd = 1'b0; prio = 1'b0;
    tick();
    chk("rst.button", 32'(bus.button), 32'd1);
    chk("rst.wren", 32'(bus.wren), 32'd0);
    chk("rst.dataIn", 32'(bus.dataIn), 32'd0);
    chk("rst.gnt", 32'(bus.gnt), 32'd0);
    chk("rst.rd_done", 32'(bus.rd_done), 32'd0);
    chk("rst.rd_src", 32'(bus.rd_src), 32'd0);
    chk("rst.result_out", 32'(bus.result_out), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.tag_cnt", 32'(dut.u_tag_fifo.count), 32'd0);
    reset = 1'b1;
    tick();

    // Single write from requester 0: A=5, B=3, ADD
    do_txn(2'b01, 15'h0143, 15'h0000, 1'b0, 1'b0, 1'b0, 6'd0, "w0", g);
    chk("w0.dataIn_const", 32'(bus.dataIn), 32'h0143);

    // Round-robin under continuous contention from a fresh reset
    do_reset();
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      do_txn(2'b11, rand_cmd(), rand_cmd(), 1'b0, 1'b0, 1'b0, 6'd0, "rr", g);
      chk("rr.seq", 32'(g), 32'(exp_seq[i]));
    end

    // Result returns carry the issuing requester's ID in order
    do_reset();
    do_txn(2'b10, rand_cmd(), rand_cmd(), 1'b0, 1'b0, 1'b0, 6'd0, "src_w1", g);
    do_txn(2'b01, rand_cmd(), rand_cmd(), 1'b0, 1'b0, 1'b0, 6'd0, "src_w0", g);
    do_txn(2'b00, 15'h0, 15'h0, 1'b1, 1'b0, 1'b0, 6'd8, "src_r1", g);
    chk("src_r1.rd_src_const", 32'(bus.rd_src), 32'd1);
    chk("src_r1.result_const", 32'(bus.result_out), 32'd8);
    do_txn(2'b00, 15'h0, 15'h0, 1'b1, 1'b0, 1'b0, 6'd8, "src_r0", g);
    chk("src_r0.rd_src_const", 32'(bus.rd_src), 32'd0);

    // Tag FIFO fills at 8 and blocks further writes until a read drains one
    do_reset();
    for (int i = 0; i < 8; i++)
      do_txn(2'($urandom_range(1, 3)), rand_cmd(), rand_cmd(), 1'b0, 1'b0, 1'b0, 6'd0, "fill", g);
    chk("fill.cnt8", 32'(dut.u_tag_fifo.count), 32'd8);
    for (int i = 0; i < 3; i++)
      do_txn(2'b01, rand_cmd(), rand_cmd(), 1'b0, 1'b0, 1'b0, 6'd0, "fill.blocked", g);
    do_txn(2'b01, rand_cmd(), rand_cmd(), 1'b1, 1'b0, 1'b0, 6'($urandom), "fill.rd", g);
    do_txn(2'b01, rand_cmd(), rand_cmd(), 1'b0, 1'b0, 1'b0, 6'd0, "fill.unblocked", g);
    while (tags.size() > 0)
      do_txn(2'b00, 15'h0, 15'h0, 1'b1, 1'b0, 1'b0, 6'($urandom), "drain", g);
    bus.rd_req = 1'b1;
    low = 0; bsy = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.button === 1'b0) low++;
      if (bus.busy === 1'b1) bsy++;
    end
    bus.rd_req = 1'b0;
    chk("rd_empty.button_low", 32'(low), 32'd0);
    chk("rd_empty.busy", 32'(bsy), 32'd0);

    // Reset dropped in the middle of a press
    do_reset();
    do_txn(2'b01, rand_cmd(), rand_cmd(), 1'b0, 1'b0, 1'b0, 6'd0, "prerst", g);
    do_txn(2'b10, rand_cmd(), rand_cmd(), 1'b0, 1'b0, 1'b0, 6'd0, "prerst", g);
    bus.req = 2'b01; bus.cmd0 = rand_cmd();
    tick();
    bus.req = 2'b00;
    for (int i = 0; i < 20 && bus.button !== 1'b0; i++) tick();
    chk("midrst.in_press", 32'(bus.button), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("midrst.button", 32'(bus.button), 32'd1);
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    tick();
    reset = 1'b1;
    tags.delete(); last_rd = 1'b0; prio = 1'b0;
    tick();
    chk("midrst.tag_cnt", 32'(dut.u_tag_fifo.count), 32'd0);

    // Opcode 3 command: filtered when the feature is built in, else written
    do_txn(2'b01, {3'd3, 6'd1, 6'd2}, 15'h0, 1'b0, 1'b0, 1'b0, 6'd0, "op3", g);
    chk("op3.gnt_const", 32'(g), 32'b01);
    low = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.button === 1'b0) low++;
    end
    chk("op3.idle_after", 32'(low), 32'd0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 80; i++) begin
      do_txn(2'($urandom_range(0, 3)), 15'($urandom), 15'($urandom),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             6'($urandom), "rand", g);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
